// File: rtl/spi_slave_byte_pkg.sv
// Shared constants and types for the SPI mode-0 byte slave.
// Latency: n/a (definitions only).
// Backpressure: n/a; the SPI host owns the bit clock, the slave never stalls it.
package spi_slave_byte_pkg;

  localparam int SPI_BYTE_W       = 8;
  localparam int SPI_BIT_CNT_W    = 3;
  localparam int SPI_SYNC_DEFAULT = 2;

  // IDLE follows synced cs_n high, ACTIVE follows synced cs_n low.
  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } spi_state_e;

endpackage

// File: rtl/spi_slave_byte_sync_bit.sv
// Single-bit synchroniser: STAGES-deep flop chain with a selectable reset level.
// Latency: STAGES clk from i_async to o_sync.
// Backpressure: none; the chain samples every clk.
// Ports: clk, resetn (async active-low), i_async (raw pin), o_sync (clk-domain level).
module spi_slave_byte_sync_bit #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic resetn,
  input  logic i_async,
  output logic o_sync
);

  logic [STAGES-1:0] r_chain;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_chain <= {STAGES{RST_VAL}};
    end else begin
      r_chain <= {r_chain[STAGES-2:0], i_async};
    end
  end

  assign o_sync = r_chain[STAGES-1];

endmodule

// File: rtl/spi_slave_byte.sv
// SPI mode-0 slave (MSB first): assembles MOSI bytes, shifts txd_data out on MISO, frames on CS_N.
// Latency: pin edge to action SYNC_STAGES+1 clk; rxd_flag/txd_load/frame_* are 1-clk pulses.
// Backpressure: none; the ADC FSM must refresh txd_data within one SCLK high time of rxd_flag.
// Ports: clk/resetn; spi_sclk/spi_cs_n/spi_mosi in, spi_miso/spi_miso_oe out;
//        txd_data in + txd_load pulse; rxd_data + rxd_flag pulse; frame_start/end/abort pulses, frame_bytes.
module spi_slave_byte
  import spi_slave_byte_pkg::*;
#(
  parameter int SYNC_STAGES = SPI_SYNC_DEFAULT,
  parameter int CNT_W       = 16
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  spi_sclk,
  input  logic                  spi_cs_n,
  input  logic                  spi_mosi,
  output logic                  spi_miso,
  output logic                  spi_miso_oe,
  input  logic [SPI_BYTE_W-1:0] txd_data,
  output logic                  txd_load,
  output logic [SPI_BYTE_W-1:0] rxd_data,
  output logic                  rxd_flag,
  output logic                  frame_start,
  output logic                  frame_end,
  output logic                  frame_abort,
  output logic [CNT_W-1:0]      frame_bytes
);

  logic w_sclk_s, w_cs_n_s, w_mosi_s;
  logic r_sclk_d, r_cs_n_d;

  // cs_n resets to 1 so a cs_n held low through reset release shows up as a clean fall.
  spi_slave_byte_sync_bit #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .resetn(resetn), .i_async(spi_sclk), .o_sync(w_sclk_s));
  spi_slave_byte_sync_bit #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs_n (
    .clk(clk), .resetn(resetn), .i_async(spi_cs_n), .o_sync(w_cs_n_s));
  spi_slave_byte_sync_bit #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .resetn(resetn), .i_async(spi_mosi), .o_sync(w_mosi_s));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_sclk_d <= 1'b0;
      r_cs_n_d <= 1'b1;
    end else begin
      r_sclk_d <= w_sclk_s;
      r_cs_n_d <= w_cs_n_s;
    end
  end

  logic w_sclk_rise, w_sclk_fall, w_cs_fall, w_cs_rise;
  assign w_sclk_rise =  w_sclk_s & ~r_sclk_d;
  assign w_sclk_fall = ~w_sclk_s &  r_sclk_d;
  assign w_cs_fall   = ~w_cs_n_s &  r_cs_n_d;
  assign w_cs_rise   =  w_cs_n_s & ~r_cs_n_d;

  spi_state_e r_state, w_state_nxt;
  logic       w_start, w_end, w_rx_step, w_tx_step;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Frame edges take priority over SCLK edges landing in the same clk; those SCLK edges are dropped.
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_end       = 1'b0;
    w_rx_step   = 1'b0;
    w_tx_step   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_cs_fall) begin
          w_state_nxt = ST_ACTIVE;
          w_start     = 1'b1;
        end
      end
      ST_ACTIVE: begin
        if (w_cs_rise) begin
          w_state_nxt = ST_IDLE;
          w_end       = 1'b1;
        end else if (w_sclk_rise) begin
          w_rx_step = 1'b1;
        end else if (w_sclk_fall) begin
          w_tx_step = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  logic [SPI_BIT_CNT_W-1:0] r_bit_cnt;
  logic [SPI_BYTE_W-1:0]    r_rx_shift, r_tx_shift, w_rx_next;
  logic                     w_byte_done;

  assign w_rx_next   = {r_rx_shift[SPI_BYTE_W-2:0], w_mosi_s};
  assign w_byte_done = w_rx_step && (r_bit_cnt == '1);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_bit_cnt   <= '0;
      r_rx_shift  <= '0;
      r_tx_shift  <= '0;
      rxd_data    <= '0;
      rxd_flag    <= 1'b0;
      txd_load    <= 1'b0;
      frame_start <= 1'b0;
      frame_end   <= 1'b0;
      frame_abort <= 1'b0;
      frame_bytes <= '0;
    end else begin
      rxd_flag    <= 1'b0;
      txd_load    <= 1'b0;
      frame_start <= 1'b0;
      frame_end   <= 1'b0;
      frame_abort <= 1'b0;
      if (w_start) begin
        r_bit_cnt   <= '0;
        r_rx_shift  <= '0;
        r_tx_shift  <= txd_data;
        txd_load    <= 1'b1;
        frame_start <= 1'b1;
        frame_bytes <= '0;
      end
      if (w_end) begin
        // Any partial byte is dropped; a non-zero bit count means the host cut a byte short.
        frame_end   <= 1'b1;
        frame_abort <= (r_bit_cnt != '0);
        r_bit_cnt   <= '0;
        r_rx_shift  <= '0;
        r_tx_shift  <= '0;
      end
      if (w_rx_step) begin
        r_rx_shift <= w_rx_next;
        r_bit_cnt  <= r_bit_cnt + 1'b1;
        if (w_byte_done) begin
          rxd_data    <= w_rx_next;
          rxd_flag    <= 1'b1;
          frame_bytes <= frame_bytes + 1'b1;
        end
      end
      if (w_tx_step) begin
        // bit_cnt is 0 on the fall that follows the 8th rise: fetch the next byte there.
        if (r_bit_cnt == '0) begin
          r_tx_shift <= txd_data;
          txd_load   <= 1'b1;
        end else begin
          r_tx_shift <= {r_tx_shift[SPI_BYTE_W-2:0], 1'b0};
        end
      end
    end
  end

  assign spi_miso    = r_tx_shift[SPI_BYTE_W-1];
  assign spi_miso_oe = (r_state == ST_ACTIVE);

endmodule

// File: tb/tb_spi_slave_byte.sv
// Directed bench for spi_slave_byte: mode-0 host BFM, ADC-style txd_data model, pulse monitor.
// Latency: host bit timing is counted in clk periods (half_clk per SCLK phase).
// Backpressure: n/a.
module tb_spi_slave_byte;

  localparam int SYNC  = 2;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             resetn;
  logic             spi_sclk, spi_cs_n, spi_mosi;
  logic             spi_miso, spi_miso_oe;
  logic [7:0]       txd_data;
  logic             txd_load;
  logic [7:0]       rxd_data;
  logic             rxd_flag;
  logic             frame_start, frame_end, frame_abort;
  logic [CNT_W-1:0] frame_bytes;

  spi_slave_byte #(.SYNC_STAGES(SYNC), .CNT_W(CNT_W)) dut (
    .clk(clk), .resetn(resetn),
    .spi_sclk(spi_sclk), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
    .txd_data(txd_data), .txd_load(txd_load),
    .rxd_data(rxd_data), .rxd_flag(rxd_flag),
    .frame_start(frame_start), .frame_end(frame_end), .frame_abort(frame_abort),
    .frame_bytes(frame_bytes));

  always #10 clk = ~clk;  // 50 MHz

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ADC model: txd_data comes from adc_seq[adc_idx]; index steps shortly after each rxd_flag.
  logic [7:0] adc_seq [8];
  int         adc_idx = 0;
  assign txd_data = adc_seq[adc_idx];

  // Pulse monitor, sampled on the falling clk edge; counters only ever grow.
  int   cnt_rxd = 0, cnt_load = 0, cnt_start = 0, cnt_end = 0, cnt_abort = 0, cnt_wide = 0;
  int   load_at_rx = 0;
  logic prev_rxd = 1'b0;
  logic adc_pend = 1'b0;

  initial forever begin
    @(negedge clk);
    if (adc_pend) begin
      adc_pend = 1'b0;
      if (adc_idx < 7) adc_idx++;
    end
    if (rxd_flag) begin
      cnt_rxd++;
      load_at_rx = cnt_load;
      adc_pend   = 1'b1;
    end
    if (rxd_flag && prev_rxd) cnt_wide++;
    prev_rxd = rxd_flag;
    if (txd_load)                  cnt_load++;
    if (frame_start)               cnt_start++;
    if (frame_end)                 cnt_end++;
    if (frame_end && frame_abort)  cnt_abort++;
    if (frame_end)                 adc_idx = 0;
  end

  int half_clk = 12;  // ~2 MHz SCLK

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic spi_bit(input logic b, output logic m);
    spi_mosi = b;
    wait_clk(half_clk);
    spi_sclk = 1'b1;
    m = spi_miso;
    wait_clk(half_clk);
    spi_sclk = 1'b0;
  endtask

  task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
    logic m;
    for (int i = 7; i >= 0; i--) begin
      spi_bit(tx[i], m);
      rx[i] = m;
    end
  endtask

  task automatic cs_high();
    wait_clk(half_clk);
    spi_cs_n = 1'b1;
    wait_clk(half_clk);
  endtask

  logic [7:0] rd, m;
  logic [7:0] exp_s [7];
  int b_rxd, b_load, b_start, b_end, b_abort;

  task automatic snap();
    b_rxd = cnt_rxd; b_load = cnt_load; b_start = cnt_start; b_end = cnt_end; b_abort = cnt_abort;
  endtask

  initial begin
    resetn = 1'b0; spi_sclk = 1'b0; spi_cs_n = 1'b1; spi_mosi = 1'b0;
    for (int i = 0; i < 8; i++) adc_seq[i] = 8'h00;
    wait_clk(3);
    check("rst_oe", spi_miso_oe, 0);
    check("rst_miso", spi_miso, 0);
    check("rst_rxd_data", rxd_data, 0);
    check("rst_pulses", {txd_load, rxd_flag, frame_start, frame_end, frame_abort}, 0);
    check("rst_frame_bytes", frame_bytes, 0);
    resetn = 1'b1;
    wait_clk(5);

    // Single byte: slave sends 5A, host sends C3.
    adc_seq[0] = 8'h5A;
    snap();
    spi_cs_n = 1'b0;
    spi_byte(8'hC3, rd);
    wait_clk(half_clk);
    check("t1_oe_active", spi_miso_oe, 1);
    cs_high();
    check("t1_miso_byte", rd, 8'h5A);
    check("t1_rxd_data", rxd_data, 8'hC3);
    check("t1_rxd_flags", cnt_rxd - b_rxd, 1);
    check("t1_frame_bytes", frame_bytes, 1);
    check("t1_start_end", {cnt_start - b_start, cnt_end - b_end}, {32'd1, 32'd1});
    check("t1_no_abort", cnt_abort - b_abort, 0);
    check("t1_oe_idle", {spi_miso_oe, spi_miso}, 0);

    // ADC-style stream of 7 bytes.
    exp_s = '{8'h5A, 8'h34, 8'h12, 8'hD0, 8'hD1, 8'hD2, 8'hD3};
    for (int i = 0; i < 7; i++) adc_seq[i] = exp_s[i];
    snap();
    spi_cs_n = 1'b0;
    for (int k = 0; k < 7; k++) begin
      spi_byte(8'(k + 1), rd);
      check($sformatf("stream_b%0d", k), rd, exp_s[k]);
    end
    cs_high();
    check("stream_rxd_flags", cnt_rxd - b_rxd, 7);
    check("stream_loads", load_at_rx - b_load, 7);
    check("stream_frame_bytes", frame_bytes, 7);
    check("stream_rxd_data", rxd_data, 8'h07);

    // Abort after 5 bits.
    snap();
    spi_cs_n = 1'b0;
    for (int i = 0; i < 5; i++) spi_bit(1'b1, m[0]);
    cs_high();
    check("abort_flag", cnt_abort - b_abort, 1);
    check("abort_end", cnt_end - b_end, 1);
    check("abort_no_rxd", cnt_rxd - b_rxd, 0);
    check("abort_rxd_data_held", rxd_data, 8'h07);
    check("abort_frame_bytes", frame_bytes, 0);

    // CS rise and 8th SCLK rise arrive together.
    snap();
    spi_cs_n = 1'b0;
    for (int i = 0; i < 7; i++) spi_bit(1'b1, m[0]);
    spi_mosi = 1'b0;
    wait_clk(half_clk);
    spi_sclk = 1'b1; spi_cs_n = 1'b1;
    wait_clk(half_clk);
    spi_sclk = 1'b0;
    wait_clk(half_clk);
    check("coll_no_rxd", cnt_rxd - b_rxd, 0);
    check("coll_abort", cnt_abort - b_abort, 1);
    check("coll_rxd_data_held", rxd_data, 8'h07);

    // Reset after 3 bits, then a clean frame.
    adc_seq[0] = 8'h3C;
    spi_cs_n = 1'b0;
    for (int i = 0; i < 3; i++) spi_bit(1'b1, m[0]);
    wait_clk(2);
    resetn = 1'b0;
    #1;
    check("rstmid_oe", spi_miso_oe, 0);
    check("rstmid_rxd_data", rxd_data, 0);
    check("rstmid_pulses", {txd_load, rxd_flag, frame_start, frame_end, frame_abort, spi_miso}, 0);
    wait_clk(1);
    spi_cs_n = 1'b1;
    wait_clk(3);
    resetn = 1'b1;
    wait_clk(5);
    snap();
    spi_cs_n = 1'b0;
    spi_byte(8'hA5, rd);
    cs_high();
    check("rstmid_rx_a5", rxd_data, 8'hA5);
    check("rstmid_rxd_flags", cnt_rxd - b_rxd, 1);
    check("rstmid_frame_bytes", frame_bytes, 1);
    check("rstmid_tx", rd, 8'h3C);

    // Minimum SCLK phase: SYNC+2 clk, 4 bytes.
    half_clk = SYNC + 2;
    adc_seq[0] = 8'h96; adc_seq[1] = 8'h69; adc_seq[2] = 8'h0F; adc_seq[3] = 8'hF0;
    snap();
    spi_cs_n = 1'b0;
    spi_byte(8'h81, rd); check("min_b0", rd, 8'h96);
    spi_byte(8'h7E, rd); check("min_b1", rd, 8'h69);
    spi_byte(8'h00, rd); check("min_b2", rd, 8'h0F);
    check("min_rx_b2", rxd_data, 8'h00);
    spi_byte(8'hFF, rd); check("min_b3", rd, 8'hF0);
    cs_high();
    wait_clk(4);
    check("min_rxd_flags", cnt_rxd - b_rxd, 4);
    check("min_frame_bytes", frame_bytes, 4);
    check("min_rxd_data", rxd_data, 8'hFF);
    check("min_no_abort", cnt_abort - b_abort, 0);
    check("rxd_flag_width", cnt_wide, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
